// File: rtl/register_bank_pkg.sv
// Shared sizing helpers, default geometry and write-request type for the register bank.
// Pure declarations: no logic, no latency.
package register_bank_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NREAD_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  localparam int AW_DEF = clog2(DEPTH_DEF);

  typedef struct packed {
    logic                 en;
    logic [AW_DEF-1:0]    adr;
    logic [WIDTH_DEF-1:0] value;
  } wr_req_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy bits with reserve-over-clear priority and an incrementally kept busy_count.
// Busy lookup is combinational; set/clear and count take effect one cycle later. No backpressure.
module register_scoreboard
  import register_bank_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 5,
  parameter int CW    = 6,
  parameter int NREAD = NREAD_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               set_en,
  input  logic [AW-1:0]      set_adr,
  input  logic               clr0_en,
  input  logic [AW-1:0]      clr0_adr,
  input  logic               clr1_en,
  input  logic [AW-1:0]      clr1_adr,
  input  logic [NREAD*AW-1:0] look_adr,
  output logic [NREAD-1:0]   look_busy,
  output logic [CW-1:0]      busy_count
);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             inc;
  logic             dec0;
  logic             dec1;
  logic [CW-1:0]    count_nxt;
  logic [AW-1:0]    la;

  // Enables arrive already qualified (in range, not a hardwired zero register).
  always_comb begin
    busy_nxt = busy;
    if (clr0_en) busy_nxt[clr0_adr] = 1'b0;
    if (clr1_en) busy_nxt[clr1_adr] = 1'b0;
    if (set_en)  busy_nxt[set_adr]  = 1'b1;

    inc  = set_en && !busy[set_adr];
    dec0 = clr0_en && busy[clr0_adr] && !(set_en && set_adr == clr0_adr);
    // A second clear of the same register must not count twice.
    dec1 = clr1_en && busy[clr1_adr] && !(set_en && set_adr == clr1_adr)
           && !(clr0_en && clr0_adr == clr1_adr);
    count_nxt = busy_count + CW'(inc) - CW'(dec0) - CW'(dec1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  always_comb begin
    look_busy = '0;
    la        = '0;
    for (int i = 0; i < NREAD; i++) begin
      la = look_adr[i*AW +: AW];
      if (32'(la) < DEPTH) look_busy[i] = busy[la];
    end
  end

endmodule

// File: rtl/register_bank_scoreboarded.sv
// Multi-port register bank: NREAD combinational reads, two prioritised write ports, optional bypass
// and zero register, plus a busy scoreboard. Reads 0 cycles, writes/reserves 1 cycle; never stalls.
module register_bank_scoreboarded
  import register_bank_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int DEPTH    = DEPTH_DEF,
  parameter  int NREAD    = NREAD_DEF,
  parameter  int ZERO_REG = 0,
  parameter  int BYPASS   = 1,
  localparam int AW       = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
  localparam int CW       = clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    radr,
  output logic [NREAD*WIDTH-1:0] rvalue,
  output logic [NREAD-1:0]       rbusy,
  input  logic                   wen0,
  input  logic [AW-1:0]          wadr0,
  input  logic [WIDTH-1:0]       wvalue0,
  input  logic                   wen1,
  input  logic [AW-1:0]          wadr1,
  input  logic [WIDTH-1:0]       wvalue1,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_adr,
  output logic [CW-1:0]          busy_count
);

  // True for addresses that hold real, writable state.
  function automatic logic adr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w0_ok;
  logic             w1_ok;
  logic             rsv_ok;
  logic [NREAD-1:0] sb_busy;
  logic [AW-1:0]    ra;
  logic [WIDTH-1:0] rd;
  logic             hit;

  assign w0_ok  = wen0   && adr_ok(wadr0);
  assign w1_ok  = wen1   && adr_ok(wadr1);
  assign rsv_ok = rsv_en && adr_ok(rsv_adr);

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      if (w0_ok) mem[wadr0] <= wvalue0;
      if (w1_ok) mem[wadr1] <= wvalue1;
    end
  end

  register_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW),
    .NREAD (NREAD)
  ) u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .set_en     (rsv_ok),
    .set_adr    (rsv_adr),
    .clr0_en    (w0_ok),
    .clr0_adr   (wadr0),
    .clr1_en    (w1_ok),
    .clr1_adr   (wadr1),
    .look_adr   (radr),
    .look_busy  (sb_busy),
    .busy_count (busy_count)
  );

  always_comb begin
    rvalue = '0;
    rbusy  = '0;
    ra     = '0;
    rd     = '0;
    hit    = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      ra  = radr[i*AW +: AW];
      rd  = '0;
      hit = 1'b0;
      if (adr_ok(ra)) rd = mem[ra];
      if (BYPASS != 0) begin
        if (w1_ok && wadr1 == ra) begin
          rd  = wvalue1;
          hit = 1'b1;
        end else if (w0_ok && wadr0 == ra) begin
          rd  = wvalue0;
          hit = 1'b1;
        end
      end
      rvalue[i*WIDTH +: WIDTH] = rd;
      // Data arriving this cycle means the pending producer has completed.
      rbusy[i] = sb_busy[i] && !hit;
    end
  end

endmodule

// File: tb/tb_register_bank_scoreboarded.sv
// Bench for register_bank_scoreboarded: four configurations driven in lockstep,
// checked every cycle against an array model plus hand-computed literals.
module tb_register_bank_scoreboarded;
  import register_bank_pkg::*;

  localparam int NI = 4;
  localparam int NR = 4;
  localparam int W  = 32;
  localparam int AWT = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR*AWT-1:0] radr;
  wr_req_t          w0, w1;
  logic             rsv_en;
  logic [AWT-1:0]   rsv_adr;

  logic [NR*W-1:0] rv_a, rv_b, rv_c, rv_d;
  logic [NR-1:0]   rb_a, rb_b, rb_c, rb_d;
  logic [5:0]      bc_a, bc_c;
  logic [4:0]      bc_b, bc_d;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // A: 32 regs, bypass. B: 20 regs, zero reg. C: 32 regs, no bypass. D: 20 regs, bypass.
  register_bank_scoreboarded #(.DEPTH(32), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .radr(radr), .rvalue(rv_a), .rbusy(rb_a),
    .wen0(w0.en), .wadr0(w0.adr), .wvalue0(w0.value), .wen1(w1.en), .wadr1(w1.adr),
    .wvalue1(w1.value), .rsv_en(rsv_en), .rsv_adr(rsv_adr), .busy_count(bc_a));
  register_bank_scoreboarded #(.DEPTH(20), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .radr(radr), .rvalue(rv_b), .rbusy(rb_b),
    .wen0(w0.en), .wadr0(w0.adr), .wvalue0(w0.value), .wen1(w1.en), .wadr1(w1.adr),
    .wvalue1(w1.value), .rsv_en(rsv_en), .rsv_adr(rsv_adr), .busy_count(bc_b));
  register_bank_scoreboarded #(.DEPTH(32), .ZERO_REG(0), .BYPASS(0)) dut_c (
    .clock(clock), .reset(reset), .radr(radr), .rvalue(rv_c), .rbusy(rb_c),
    .wen0(w0.en), .wadr0(w0.adr), .wvalue0(w0.value), .wen1(w1.en), .wadr1(w1.adr),
    .wvalue1(w1.value), .rsv_en(rsv_en), .rsv_adr(rsv_adr), .busy_count(bc_c));
  register_bank_scoreboarded #(.DEPTH(20), .ZERO_REG(0), .BYPASS(1)) dut_d (
    .clock(clock), .reset(reset), .radr(radr), .rvalue(rv_d), .rbusy(rb_d),
    .wen0(w0.en), .wadr0(w0.adr), .wvalue0(w0.value), .wen1(w1.en), .wadr1(w1.adr),
    .wvalue1(w1.value), .rsv_en(rsv_en), .rsv_adr(rsv_adr), .busy_count(bc_d));

  function automatic int dep(input int k);
    return (k % 2 == 1) ? 20 : 32;
  endfunction
  function automatic bit zr(input int k);
    return k == 1;
  endfunction
  function automatic bit byp(input int k);
    return k != 2;
  endfunction
  function automatic bit valid(input int k, input int a);
    return (a < dep(k)) && !(zr(k) && a == 0);
  endfunction

  function automatic logic [31:0] rdv(input int k, input int p);
    logic [NR*W-1:0] v;
    case (k)
      0: v = rv_a;
      1: v = rv_b;
      2: v = rv_c;
      default: v = rv_d;
    endcase
    return v[p*W +: W];
  endfunction
  function automatic logic [31:0] rdb(input int k, input int p);
    logic [NR-1:0] v;
    case (k)
      0: v = rb_a;
      1: v = rb_b;
      2: v = rb_c;
      default: v = rb_d;
    endcase
    return {31'b0, v[p]};
  endfunction
  function automatic logic [31:0] bcv(input int k);
    case (k)
      0: return {26'b0, bc_a};
      1: return {27'b0, bc_b};
      2: return {26'b0, bc_c};
      default: return {27'b0, bc_d};
    endcase
  endfunction

  // Model state: plain arrays of stored values and busy flags per configuration.
  logic [31:0] m_mem  [NI][32];
  bit          m_busy [NI][32];
  bit          m_on = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NI; k++)
        for (int r = 0; r < 32; r++) begin
          m_mem[k][r]  <= '0;
          m_busy[k][r] <= 1'b0;
        end
      m_on <= 1'b1;
    end else if (m_on) begin
      for (int k = 0; k < NI; k++) begin
        if (w0.en && valid(k, int'(w0.adr))) m_mem[k][w0.adr] <= w0.value;
        if (w1.en && valid(k, int'(w1.adr))) m_mem[k][w1.adr] <= w1.value;
        for (int r = 0; r < 32; r++) begin
          bit rs;
          bit wr;
          rs = rsv_en && int'(rsv_adr) == r && valid(k, r);
          wr = valid(k, r) && ((w0.en && int'(w0.adr) == r) || (w1.en && int'(w1.adr) == r));
          if (rs) m_busy[k][r] <= 1'b1;
          else if (wr) m_busy[k][r] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      for (int k = 0; k < NI; k++) begin
        int pc;
        for (int p = 0; p < NR; p++) begin
          int a;
          logic [31:0] ev;
          logic [31:0] eb;
          a = int'(radr[p*AWT +: AWT]);
          if (!valid(k, a)) begin
            ev = '0; eb = '0;
          end else if (byp(k) && w1.en && int'(w1.adr) == a) begin
            ev = w1.value; eb = '0;
          end else if (byp(k) && w0.en && int'(w0.adr) == a) begin
            ev = w0.value; eb = '0;
          end else begin
            ev = m_mem[k][a]; eb = {31'b0, m_busy[k][a]};
          end
          checks++;
          if (rdv(k, p) !== ev) begin
            failures++;
            $display("FAIL model_rvalue k=%0d port=%0d adr=%0d actual=%h required=%h", k, p, a, rdv(k, p), ev);
          end
          checks++;
          if (rdb(k, p) !== eb) begin
            failures++;
            $display("FAIL model_rbusy k=%0d port=%0d adr=%0d actual=%0d required=%0d", k, p, a, rdb(k, p), eb);
          end
        end
        pc = 0;
        for (int r = 0; r < 32; r++) pc += int'(m_busy[k][r]);
        checks++;
        if (bcv(k) !== 32'(pc)) begin
          failures++;
          $display("FAIL model_busy_count k=%0d actual=%0d required=%0d", k, bcv(k), pc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    w0 = '0; w1 = '0; rsv_en = 1'b0; rsv_adr = '0;
  endtask
  task automatic setr(input int p, input int a);
    radr[p*AWT +: AWT] = AWT'(a);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    radr = '0;
    idle();
    reset = 1'b1;
    w0 = '{en: 1'b1, adr: 5'd5, value: 32'hDEADBEEF};
    rsv_en = 1'b1; rsv_adr = 5'd5;
    tick(); tick();

    reset = 1'b0; idle();
    setr(0, 5); setr(1, 0); setr(2, 1); setr(3, 31);
    @(negedge clock);
    chk("rst_rd5_A", rdv(0, 0), 32'h0);
    chk("rst_busy5_A", rdb(0, 0), 32'h0);
    chk("rst_cnt_A", bcv(0), 32'd0);
    chk("rst_cnt_D", bcv(3), 32'd0);
    tick();

    w0 = '{en: 1'b1, adr: 5'd7, value: 32'h11111111};
    w1 = '{en: 1'b1, adr: 5'd7, value: 32'h22222222};
    setr(0, 7);
    @(negedge clock);
    chk("coll_bypass_A", rdv(0, 0), 32'h22222222);
    chk("coll_nobypass_C", rdv(2, 0), 32'h0);
    tick(); idle();
    @(negedge clock);
    chk("coll_stored_A", rdv(0, 0), 32'h22222222);
    chk("coll_stored_C", rdv(2, 0), 32'h22222222);
    tick();

    rsv_en = 1'b1; rsv_adr = 5'd3;
    tick(); idle(); setr(0, 3);
    @(negedge clock);
    chk("rsv3_busy_A", rdb(0, 0), 32'd1);
    chk("rsv3_cnt_A", bcv(0), 32'd1);
    tick();
    w1 = '{en: 1'b1, adr: 5'd3, value: 32'h0000ABCD};
    @(negedge clock);
    chk("wr3_bypass_A", rdv(0, 0), 32'h0000ABCD);
    chk("wr3_bypass_busy_A", rdb(0, 0), 32'd0);
    chk("wr3_nobypass_busy_C", rdb(2, 0), 32'd1);
    tick(); idle();
    @(negedge clock);
    chk("wr3_cnt_A", bcv(0), 32'd0);
    tick();

    rsv_en = 1'b1; rsv_adr = 5'd9;
    w0 = '{en: 1'b1, adr: 5'd9, value: 32'h00000055};
    tick(); idle(); setr(0, 9);
    @(negedge clock);
    chk("rsvwr9_val_A", rdv(0, 0), 32'h55);
    chk("rsvwr9_busy_A", rdb(0, 0), 32'd1);
    chk("rsvwr9_cnt_A", bcv(0), 32'd1);
    tick();
    w0 = '{en: 1'b1, adr: 5'd9, value: 32'h1};
    w1 = '{en: 1'b1, adr: 5'd9, value: 32'h2};
    tick(); idle();
    @(negedge clock);
    chk("dblclr9_cnt_A", bcv(0), 32'd0);
    chk("dblclr9_val_A", rdv(0, 0), 32'h2);
    tick();

    w0 = '{en: 1'b1, adr: 5'd0, value: 32'hFFFFFFFF};
    rsv_en = 1'b1; rsv_adr = 5'd0; setr(0, 0);
    @(negedge clock);
    chk("zero_same_B", rdv(1, 0), 32'h0);
    chk("r0_bypass_A", rdv(0, 0), 32'hFFFFFFFF);
    tick(); idle();
    @(negedge clock);
    chk("zero_val_B", rdv(1, 0), 32'h0);
    chk("zero_busy_B", rdb(1, 0), 32'd0);
    chk("zero_cnt_B", bcv(1), 32'd0);
    chk("r0_val_A", rdv(0, 0), 32'hFFFFFFFF);
    chk("r0_cnt_A", bcv(0), 32'd1);
    tick();
    w0 = '{en: 1'b1, adr: 5'd0, value: 32'h0};
    tick(); idle();

    for (int r = 0; r < 20; r++) begin
      rsv_en = 1'b1; rsv_adr = AWT'(r);
      tick();
    end
    rsv_en = 1'b1; rsv_adr = 5'd4;
    tick(); idle();
    @(negedge clock);
    chk("full_cnt_A", bcv(0), 32'd20);
    chk("full_cnt_B", bcv(1), 32'd19);
    chk("full_cnt_C", bcv(2), 32'd20);
    chk("full_cnt_D", bcv(3), 32'd20);
    tick();
    rsv_en = 1'b1; rsv_adr = 5'd25;
    tick(); idle();
    @(negedge clock);
    chk("oor_rsv_cnt_A", bcv(0), 32'd21);
    chk("oor_rsv_cnt_D", bcv(3), 32'd20);
    tick();
    w0 = '{en: 1'b1, adr: 5'd25, value: 32'h00000077}; setr(0, 25);
    @(negedge clock);
    chk("oor_same_D", rdv(3, 0), 32'h0);
    chk("oor_same_busy_D", rdb(3, 0), 32'd0);
    chk("oor_same_B", rdv(1, 0), 32'h0);
    chk("byp25_A", rdv(0, 0), 32'h77);
    tick(); idle();
    @(negedge clock);
    chk("oor_read_D", rdv(3, 0), 32'h0);
    chk("oor_cnt_D", bcv(3), 32'd20);
    chk("wr25_A", rdv(0, 0), 32'h77);
    chk("wr25_cnt_A", bcv(0), 32'd20);
    tick();

    for (int i = 0; i < 40; i++) begin
      idle();
      w0.en    = (i % 3 == 0);
      w0.adr   = AWT'((i * 7) % 32);
      w0.value = 32'(i) * 32'h01010101;
      w1.en    = (i % 4 == 1);
      w1.adr   = AWT'((i * 5) % 32);
      w1.value = 32'hA5000000 + 32'(i);
      rsv_en   = (i % 2 == 0);
      rsv_adr  = AWT'((i * 3) % 32);
      for (int p = 0; p < NR; p++) setr(p, (i + p * 9) % 32);
      tick();
    end

    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    setr(0, 7);
    @(negedge clock);
    for (int k = 0; k < NI; k++) chk($sformatf("final_rst_cnt_%0d", k), bcv(k), 32'd0);
    chk("final_rst_rd7_A", rdv(0, 0), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_scoreboarded.md
Name: register_bank_scoreboarded

Overview:
Parametrised successor of the CPU register bank. It has NREAD combinational read ports and two prioritised write ports (execute writeback and memory writeback). It adds synchronous reset clearing, optional same-cycle write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard with a live busy count. It sits in decode/writeback and feeds hazard detection.

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers (need not be a power of two)
NREAD, 4, number of read ports
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes/reserves, never busy
BYPASS, 1, 1 = read of an address being written this cycle returns the write data
(localparam AW = clog2(DEPTH), minimum 1; CW = clog2(DEPTH+1))

Ports:
clock  in  1  rising-edge clock; all state updates on posedge
reset  in  1  synchronous, active-high
radr  in  NREAD*AW  read addresses; port i occupies slice i
rvalue  out  NREAD*WIDTH  read data per port (combinational)
rbusy  out  NREAD  busy flag per port (combinational)
wen0  in  1  write enable, execute port
wadr0  in  AW  write address, port 0
wvalue0  in  WIDTH  write data, port 0
wen1  in  1  write enable, memory port
wadr1  in  AW  write address, port 1
wvalue1  in  WIDTH  write data, port 1
rsv_en  in  1  reserve request: mark destination busy
rsv_adr  in  AW  register to reserve
busy_count  out  CW  number of registers currently busy (registered)

Behaviour:
- Reset: reset=1 at a posedge clears all registers, busy bits and busy_count to 0. Writes and reserves in that cycle are ignored. From the next cycle every rvalue=0, rbusy=0, busy_count=0.
- Write: wenX=1 stores wvalueX into wadrX at posedge. Data is visible to unbypassed reads the following cycle.
- Write collision: wen0 and wen1 target the same address -> port 1 value is stored.
- Out of range: an address >= DEPTH on any port is ignored for writes and reserves. Reads of it return 0 with rbusy=0.
- ZERO_REG=1: reg 0 reads 0 and has rbusy=0. Writes and reserves to reg 0 are dropped and do not change busy_count.
- Read: rvalue[i] = stored[radr[i]] when there is no bypass hit.
- Bypass hit (BYPASS=1): an enabled write in the same cycle matches radr[i] (valid, nonzero if ZERO_REG). rvalue[i] = that write's data, port 1 taking priority over port 0. A bypass hit also forces rbusy[i]=0. With BYPASS=0, reads return stored values only and rbusy reflects stored busy bits.
- Busy update per register r at posedge:
  - set if reserved this cycle
  - else cleared if written this cycle by either port
  - else held
- Reserve and write to the same register in one cycle: busy stays set, and the write data is still stored.
- Reserving an already-busy register leaves it busy with no count change.
- busy_count: updated incrementally each cycle.
  - +1 for a reserve that sets a previously clear bit
  - -1 for each distinct register cleared by a write
  - Two writes to the same busy register decrement once.
  - Invariant: busy_count == popcount(busy bits) every cycle; never exceeds DEPTH and never wraps.
- Latency: reads 0 cycles (combinational); writes, reserves and count 1 cycle.

Decomposition:
- Package register_bank_pkg: clog2 function, default WIDTH/DEPTH/NREAD constants, and a typedef for a write request struct {en, adr, value}.
- One sub-module, register_scoreboard. It is parametrised by DEPTH/AW and holds the busy vector, set/clear priority and incremental busy_count. It exposes a combinational busy lookup for NREAD addresses.
- Data storage, write collision handling and bypass muxing stay in the top module.

Test Plan:
- Reset then read all ports -> every rvalue=0, rbusy=0, busy_count=0. Write reg 5=0xDEADBEEF with reset=1 held -> reg 5 still 0 after reset.
- wen0 adr 7=0x11111111 and wen1 adr 7=0x22222222 in the same cycle -> next cycle read adr 7 = 0x22222222. Same cycle with BYPASS=1, radr0=7 -> 0x22222222.
- rsv_en adr 3 -> next cycle rbusy for adr 3 =1, busy_count=1. Then wen1 adr 3=0xABCD with radr=3 -> same cycle rvalue=0xABCD, rbusy=0. Next cycle busy_count=0.
- Reserve adr 9 plus wen0 adr 9=0x55 in one cycle -> adr 9 reads 0x55 with rbusy=1, busy_count=1.
- ZERO_REG=1: wen0 adr 0=0xFFFFFFFF and rsv adr 0 -> adr 0 reads 0, rbusy 0, busy_count unchanged.
- DEPTH=20: reserve every register 0..19, then re-reserve 4 -> busy_count=20. Write adr 25 -> ignored, and read adr 25 returns 0.
